// File: rtl/traffic_pkg.sv
// Shared phase encodings, light patterns and cycle-order helper for the intersection controller.
package traffic_pkg;

    localparam logic [2:0] MAIN_G = 3'd0;
    localparam logic [2:0] MAIN_Y = 3'd1;
    localparam logic [2:0] CLR_1  = 3'd2;
    localparam logic [2:0] SIDE_G = 3'd3;
    localparam logic [2:0] SIDE_Y = 3'd4;
    localparam logic [2:0] CLR_2  = 3'd5;
    localparam logic [2:0] EMERG  = 3'd6;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    // Normal cycle successor; EMERG and illegal codes fall back to the clearance phase.
    function automatic logic [2:0] next_phase(input logic [2:0] ph);
        case (ph)
            MAIN_G:  next_phase = MAIN_Y;
            MAIN_Y:  next_phase = CLR_1;
            CLR_1:   next_phase = SIDE_G;
            SIDE_G:  next_phase = SIDE_Y;
            SIDE_Y:  next_phase = CLR_2;
            CLR_2:   next_phase = MAIN_G;
            default: next_phase = CLR_2;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_99.sv
// Combinational 7-bit binary to two-digit BCD, valid for inputs 0..99.
module bin2bcd_99 (
    input  logic [6:0] bin,
    output logic [7:0] bcd
);

    logic [3:0] tens;
    logic [3:0] ones;

    always_comb begin
        tens = 4'(bin / 7'd10);
        ones = 4'(bin % 7'd10);
        bcd  = {tens, ones};
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection sequencer: tick-timed phase cycle, side-road request shortening
// of main green, emergency all-red override, and BCD countdown for the display.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned G_MAIN  = 30,
    parameter int unsigned G_SIDE  = 20,
    parameter int unsigned Y_TIME  = 3,
    parameter int unsigned R_ALL   = 2,
    parameter int unsigned G_SHORT = 5,
    parameter int unsigned CNT_W   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       side_req,
    input  logic       emerg,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [7:0] cnt_bcd,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] CntMain  = CNT_W'(G_MAIN);
    localparam logic [CNT_W-1:0] CntSide  = CNT_W'(G_SIDE);
    localparam logic [CNT_W-1:0] CntYel   = CNT_W'(Y_TIME);
    localparam logic [CNT_W-1:0] CntClr   = CNT_W'(R_ALL);
    localparam logic [CNT_W-1:0] CntShort = CNT_W'(G_SHORT);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             req_eff;

    function automatic logic [CNT_W-1:0] duration(input logic [2:0] ph);
        case (ph)
            MAIN_G:         duration = CntMain;
            SIDE_G:         duration = CntSide;
            MAIN_Y, SIDE_Y: duration = CntYel;
            default:        duration = CntClr;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // A request in the current cycle counts immediately, not one edge later.
        req_eff = req_q | side_req;
        req_d   = req_eff;

        if (emerg) begin
            state_d = EMERG;
            cnt_d   = '0;
        end else begin
            case (state_q)
                EMERG: begin
                    state_d = CLR_2;
                    cnt_d   = CntClr;
                end
                MAIN_G, MAIN_Y, CLR_1, SIDE_G, SIDE_Y, CLR_2: begin
                    if (state_q == MAIN_G && req_eff && cnt_q > CntShort) begin
                        cnt_d = CntShort;
                    end else if (tick) begin
                        if (cnt_q > CntOne) begin
                            cnt_d = cnt_q - CntOne;
                        end else begin
                            state_d = next_phase(state_q);
                            cnt_d   = duration(state_d);
                        end
                    end
                end
                default: begin
                    state_d = CLR_2;
                    cnt_d   = CntClr;
                end
            endcase
        end

        if (state_d == SIDE_G && state_q != SIDE_G) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MAIN_G;
            cnt_q   <= CntMain;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        main_light = LT_RED;
        side_light = LT_RED;
        case (state_q)
            MAIN_G:  main_light = LT_GRN;
            MAIN_Y:  main_light = LT_YEL;
            SIDE_G:  side_light = LT_GRN;
            SIDE_Y:  side_light = LT_YEL;
            default: ;
        endcase
        phase = state_q;
    end

    bin2bcd_99 u_bin2bcd (
        .bin (7'(cnt_q)),
        .bcd (cnt_bcd)
    );

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with short phase durations and a tick every 4 clocks.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       side_req = 1'b0;
    logic       emerg = 1'b0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic [7:0] cnt_bcd;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] P_MG = 3'd0, P_MY = 3'd1, P_C1 = 3'd2, P_SG = 3'd3;
    localparam logic [2:0] P_SY = 3'd4, P_C2 = 3'd5, P_EM = 3'd6;

    traffic_light_ctrl #(
        .G_MAIN  (6),
        .G_SIDE  (4),
        .Y_TIME  (2),
        .R_ALL   (1),
        .G_SHORT (2),
        .CNT_W   (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .side_req   (side_req),
        .emerg      (emerg),
        .main_light (main_light),
        .side_light (side_light),
        .cnt_bcd    (cnt_bcd),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [2:0] ph, input logic [7:0] cnt);
        chk({tag, "_phase"}, {5'd0, phase}, {5'd0, ph});
        chk({tag, "_cnt"}, cnt_bcd, cnt);
    endtask

    // One tick pulse then idle clocks; returns at a negedge after the tick edge.
    task automatic do_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    // Safety: never both roads non-red.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (main_light == 3'b100 || side_light == 3'b100) else begin
                errors++;
                $error("FAIL safety: observed main %b side %b expected at least one red",
                       main_light, side_light);
            end
        end
    end

    logic [2:0] exp_ph  [16];
    logic [7:0] exp_cnt [16];

    initial begin
        exp_ph  = '{P_MG, P_MG, P_MG, P_MG, P_MG, P_MY, P_MY, P_C1,
                    P_SG, P_SG, P_SG, P_SG, P_SY, P_SY, P_C2, P_MG};
        exp_cnt = '{8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h02, 8'h01, 8'h01,
                    8'h04, 8'h03, 8'h02, 8'h01, 8'h02, 8'h01, 8'h01, 8'h06};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_state("reset", P_MG, 8'h06);
        chk("reset_main", {5'd0, main_light}, 8'h01);
        chk("reset_side", {5'd0, side_light}, 8'h04);

        // Free-run full cycle
        for (int k = 0; k < 16; k++) begin
            do_tick();
            chk_state($sformatf("run_t%0d", k + 1), exp_ph[k], exp_cnt[k]);
            if (exp_ph[k] == P_SG) chk("run_sg_side", {5'd0, side_light}, 8'h01);
            if (exp_ph[k] == P_MY) chk("run_my_main", {5'd0, main_light}, 8'h02);
        end

        // Side request at cnt=5 shortens main green to 2
        do_tick();
        chk_state("req_pre", P_MG, 8'h05);
        @(negedge clk) side_req = 1'b1;
        @(negedge clk) side_req = 1'b0;
        chk_state("req_load", P_MG, 8'h02);
        ticks(2);
        chk_state("req_my", P_MY, 8'h02);
        ticks(3);
        chk_state("req_sg", P_SG, 8'h04);
        ticks(7);
        repeat (3) @(negedge clk);
        chk_state("req_cleared", P_MG, 8'h06);

        // Request at cnt=1: no reload, latch cleared at SIDE_G
        ticks(5);
        @(negedge clk) side_req = 1'b1;
        @(negedge clk) side_req = 1'b0;
        chk_state("req1_noload", P_MG, 8'h01);
        do_tick();
        chk_state("req1_my", P_MY, 8'h02);
        ticks(3);
        chk_state("req1_sg", P_SG, 8'h04);
        ticks(7);
        repeat (3) @(negedge clk);
        chk_state("req1_cleared", P_MG, 8'h06);

        // Emergency during SIDE_G
        ticks(10);
        chk_state("em_pre", P_SG, 8'h03);
        @(negedge clk) emerg = 1'b1;
        @(negedge clk);
        chk_state("em_enter", P_EM, 8'h00);
        chk("em_main", {5'd0, main_light}, 8'h04);
        chk("em_side", {5'd0, side_light}, 8'h04);
        ticks(10);
        chk_state("em_hold", P_EM, 8'h00);
        emerg = 1'b0;
        @(negedge clk);
        chk_state("em_exit", P_C2, 8'h01);
        do_tick();
        chk_state("em_main_g", P_MG, 8'h06);

        // Tick and emerg together at MAIN_Y cnt=1
        ticks(7);
        chk_state("tie_pre", P_MY, 8'h01);
        @(negedge clk) begin tick = 1'b1; emerg = 1'b1; end
        @(negedge clk) begin tick = 1'b0; emerg = 1'b0; end
        chk_state("tie_em", P_EM, 8'h00);
        @(negedge clk);
        chk_state("tie_c2", P_C2, 8'h01);
        do_tick();
        chk_state("tie_mg", P_MG, 8'h06);

        // Reset mid SIDE_Y, with tick and emerg asserted alongside
        ticks(13);
        chk_state("rst_pre", P_SY, 8'h02);
        @(negedge clk) begin rst = 1'b1; tick = 1'b1; emerg = 1'b1; end
        @(negedge clk) begin rst = 1'b0; tick = 1'b0; emerg = 1'b0; end
        chk_state("rst_mid", P_MG, 8'h06);
        chk("rst_main", {5'd0, main_light}, 8'h01);
        chk("rst_side", {5'd0, side_light}, 8'h04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
